edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Per-channel edge detection and event scheduling for N_CH asynchronous input lines.
//  Each line is synchronized and edge-detected (rising and/or falling, per-channel enables).
//  Each detected edge is queued in a one-deep per-channel slot.
//  A round-robin arbiter serializes the queued events onto one valid/ready event port.
//  It sits between raw board inputs (buttons, sensor lines) and a single event consumer.
// PARAMETERS
//  N_CH         4  number of input channels, legal range 2..16
//  SYNC_STAGES  2  synchronizer flop depth per channel, minimum 2
//  CH_W         $clog2(N_CH)  derived localparam, event channel index width
// PORTS
//  clk           input   1      single clock, all state on posedge
//  rst           input   1      reset, asynchronous assert, active-low (0 = reset)
//  in            input   N_CH   raw asynchronous input lines
//  rise_en       input   N_CH   per-channel: report rising edges
//  fall_en       input   N_CH   per-channel: report falling edges
//  evt_valid     output  1      event present on evt_ch/evt_rising
//  evt_ready     input   1      consumer accepts event when evt_valid & evt_ready
//  evt_ch        output  CH_W   channel index of the presented event
//  evt_rising    output  1      1 = rising edge, 0 = falling edge
//  pending       output  N_CH   per-channel slot-occupied flags
//  overflow      output  N_CH   sticky: an edge was dropped on that channel
//  clr_overflow  input   1      one-cycle pulse, clears all overflow bits
// BEHAVIOUR
//  Reset (rst=0), applied asynchronously:
//   - sync flops, prev-sample flops, pending slots and stored polarities = 0
//   - evt_valid=0, evt_ch=0, evt_rising=0, overflow=0
//   - round-robin pointer = N_CH-1, so ch0 has first priority
//  Detection:
//   - s = last synchronizer stage; p = s delayed one cycle
//   - rise = s&~p&rise_en; fall = ~s&p&fall_en
//   - Enables are applied at detection only; clearing an enable does not flush a queued slot.
//   - Input high at reset release: reported as a rising edge, because p resets to 0.
//  Latency:
//   - Posedge 0 is the first edge to sample a changed in.
//   - Pending slot is set at posedge SYNC_STAGES.
//   - evt_valid is asserted after posedge SYNC_STAGES+1 (default: after the 4th edge), if the output is free and no arbitration loss.
//   - Minimum input pulse/gap for both edges to be seen: 1 synchronized cycle.
//  Slot rules, per channel, per cycle:
//   - Edge and slot empty -> store, pending=1.
//   - Edge and slot full, and slot not being loaded to the output this cycle -> drop the new edge (old kept), overflow=1.
//   - Edge and slot being loaded to the output this cycle -> store new edge, no overflow.
//  Output register:
//   - Output is free when evt_valid=0 or (evt_valid & evt_ready).
//   - When free and any pending: load the winning channel, clear its slot, evt_valid=1, pointer := winner.
//   - When free and none pending: evt_valid=0.
//   - While evt_valid & ~evt_ready: evt_valid, evt_ch and evt_rising are held stable.
//   - Throughput: one event per cycle while evt_ready=1.
//  Arbitration:
//   - Scan from pointer+1, wrapping modulo N_CH; first pending channel wins.
//   - The pointer is unchanged when no load occurs.
//  overflow: set has priority over clr_overflow in the same cycle, for that bit.
//  Reset mid-operation: all state drops immediately, including a held event; queued events are lost.
// TESTING
//  1. rst=0 while in toggles -> evt_valid=0, pending=0, overflow=0 throughout; release with in=0 -> no events.
//  2. rise_en=fall_en=4'hF, evt_ready=1, in[2] 0->1 -> one evt_valid cycle after posedge 3, evt_ch=2, evt_rising=1.
//     Later in[2] 1->0 -> evt_ch=2, evt_rising=0.
//  3. in[0],in[1],in[3] rise on the same cycle, evt_ready=1 -> evt_ch 0,1,3 on consecutive cycles.
//     Then ch3 and ch0 rise together -> ch0 first, then ch3.
//  4. evt_ready=0; in[1] rises, falls and rises again, 4 cycles apart.
//     -> output holds ch1/rise; slot holds fall; overflow[1]=1; the third edge is dropped.
//     evt_ready=1 -> rise then fall delivered; clr_overflow -> overflow=0.
//  5. fall_en=0, rise_en=4'hF; toggle in[0] three times (0->1->0->1) -> exactly two events, both evt_rising=1.
//  6. evt_valid held with evt_ready=0, then rst=0 mid-cycle -> evt_valid=0 before next posedge.
//     Release with in[3]=1 -> single ch3 rising event.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Synchronizes N_CH asynchronous lines and detects their edges. Each edge waits in a one-deep
// per-channel slot until a round-robin arbiter sends it out on a single valid/ready event port.
module edge_event_arbiter #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rising,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow,
    input  logic            clr_overflow
);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_r;
    logic [N_CH-1:0] prev_r;
    logic [N_CH-1:0] slot_r;
    logic [N_CH-1:0] pol_r;
    logic [N_CH-1:0] ovf_r;
    logic [N_CH-1:0] slot_nxt_s;
    logic [N_CH-1:0] pol_nxt_s;
    logic [N_CH-1:0] ovf_set_s;
    logic [N_CH-1:0] s_s;
    logic [N_CH-1:0] rise_s;
    logic [N_CH-1:0] fall_s;
    logic [N_CH-1:0] edge_s;
    logic [N_CH-1:0] load_mask_s;
    logic            evt_valid_r;
    logic            evt_rising_r;
    logic [CH_W-1:0] evt_ch_r;
    logic [CH_W-1:0] ptr_r;
    logic [CH_W-1:0] win_idx_s;
    logic            win_found_s;
    logic            out_free_s;
    logic            load_s;

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        return (sum >= N_CH) ? CH_W'(sum - N_CH) : CH_W'(sum);
    endfunction

    // Synchronizer chain plus a one-cycle-delayed copy of its last stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign s_s    = sync_r[SYNC_STAGES-1];
    assign rise_s = s_s & ~prev_r & rise_en;
    assign fall_s = ~s_s & prev_r & fall_en;
    assign edge_s = rise_s | fall_s;

    // Round-robin pick: scan upward from the channel after the last winner.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!win_found_s && slot_r[rr_idx(ptr_r, i)]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_idx(ptr_r, i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign out_free_s  = ~evt_valid_r | evt_ready;
    assign load_s      = out_free_s & win_found_s;
    assign load_mask_s = ({{(N_CH-1){1'b0}}, 1'b1} << win_idx_s) & {N_CH{load_s}};

    // Slot update: a slot that drains this cycle can take a new edge without losing it.
    always_comb begin
        slot_nxt_s = slot_r;
        pol_nxt_s  = pol_r;
        ovf_set_s  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (load_mask_s[c]) begin
                slot_nxt_s[c] = edge_s[c];
                pol_nxt_s[c]  = rise_s[c];
            end else if (edge_s[c] && !slot_r[c]) begin
                slot_nxt_s[c] = 1'b1;
                pol_nxt_s[c]  = rise_s[c];
            end else if (edge_s[c]) begin
                ovf_set_s[c] = 1'b1;
            end else begin
                ovf_set_s[c] = 1'b0;
            end
        end
    end

    // Slot, polarity and sticky overflow registers. A set wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_r <= '0;
            pol_r  <= '0;
            ovf_r  <= '0;
        end else begin
            slot_r <= slot_nxt_s;
            pol_r  <= pol_nxt_s;
            ovf_r  <= (ovf_r & ~{N_CH{clr_overflow}}) | ovf_set_s;
        end
    end

    // Output register and round-robin pointer. A stalled event holds every field.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid_r  <= 1'b0;
            evt_ch_r     <= '0;
            evt_rising_r <= 1'b0;
            ptr_r        <= CH_W'(N_CH - 1);
        end else if (load_s) begin
            evt_valid_r  <= 1'b1;
            evt_ch_r     <= win_idx_s;
            evt_rising_r <= pol_r[win_idx_s];
            ptr_r        <= win_idx_s;
        end else if (out_free_s) begin
            evt_valid_r  <= 1'b0;
        end
    end

    assign evt_valid  = evt_valid_r;
    assign evt_ch     = evt_ch_r;
    assign evt_rising = evt_rising_r;
    assign pending    = slot_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter. A table of per-cycle vectors covers the basic flows,
// and hand-written sequences cover stall/overflow, masked falling edges and reset mid-event.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_rising;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic       clr_overflow;

    int total = 0;
    int bad   = 0;
    int ev_cnt;
    int ev_bad;

    typedef struct {
        logic [3:0] din;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_ch;
        logic       exp_rising;
        logic [3:0] exp_pend;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];

    edge_event_arbiter #(.N_CH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in(din), .rise_en(rise_en), .fall_en(fall_en),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_rising(evt_rising), .pending(pending), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s idx=%0d got=%0h want=%0h", nm, idx, got, want);
        end
    endtask

    task automatic row(input logic [3:0] i, input logic v, input logic [1:0] ch, input logic r,
                       input logic [3:0] pend);
        vec_t t;
        t.din = i; t.rdy = 1'b1; t.exp_valid = v; t.exp_ch = ch;
        t.exp_rising = r; t.exp_pend = pend; t.exp_ovf = 4'h0;
        vecs.push_back(t);
    endtask

    // Step n cycles with evt_ready=1, counting events and flagging any not on ch / rising.
    task automatic run(input int n, input logic [1:0] ch);
        for (int k = 0; k < n; k++) begin
            step();
            if (evt_valid) begin
                ev_cnt++;
                if (evt_ch !== ch || evt_rising !== 1'b1) ev_bad++;
            end
        end
    endtask

    initial begin
        // idle after reset release
        for (int k = 0; k < 4; k++) row(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000);
        // ch0,1,3 rise together: pointer starts at 3 so order is 0,1,3
        row(4'b1011, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1011, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1011, 1'b0, 2'd0, 1'b0, 4'b1011);
        row(4'b1011, 1'b1, 2'd0, 1'b1, 4'b1010);
        row(4'b1011, 1'b1, 2'd1, 1'b1, 4'b1000);
        row(4'b1011, 1'b1, 2'd3, 1'b1, 4'b0000);
        row(4'b1011, 1'b0, 2'd0, 1'b0, 4'b0000);
        // the same three fall together
        row(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b0000, 1'b0, 2'd0, 1'b0, 4'b1011);
        row(4'b0000, 1'b1, 2'd0, 1'b0, 4'b1010);
        row(4'b0000, 1'b1, 2'd1, 1'b0, 4'b1000);
        row(4'b0000, 1'b1, 2'd3, 1'b0, 4'b0000);
        row(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000);
        // ch3 and ch0 rise with pointer at 3: ch0 first
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b1001);
        row(4'b1001, 1'b1, 2'd0, 1'b1, 4'b1000);
        row(4'b1001, 1'b1, 2'd3, 1'b1, 4'b0000);
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b0000);
        // ch2 rise then fall, one event cycle each
        row(4'b1101, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1101, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1101, 1'b0, 2'd0, 1'b0, 4'b0100);
        row(4'b1101, 1'b1, 2'd2, 1'b1, 4'b0000);
        row(4'b1101, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b0000);
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b0100);
        row(4'b1001, 1'b1, 2'd2, 1'b0, 4'b0000);
        row(4'b1001, 1'b0, 2'd0, 1'b0, 4'b0000);

        rst = 1'b0; din = 4'h0; rise_en = 4'hF; fall_en = 4'hF;
        evt_ready = 1'b1; clr_overflow = 1'b0;

        // held in reset while inputs toggle
        for (int k = 0; k < 6; k++) begin
            din = 4'(k * 7 + 5);
            step();
            chk("rst_valid", k, 32'(evt_valid), 32'd0);
            chk("rst_pend", k, 32'(pending), 32'd0);
            chk("rst_ovf", k, 32'(overflow), 32'd0);
            chk("rst_ch", k, 32'(evt_ch), 32'd0);
            chk("rst_rising", k, 32'(evt_rising), 32'd0);
        end
        din = 4'h0;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            din = vecs[i].din;
            evt_ready = vecs[i].rdy;
            step();
            chk("vec_valid", i, 32'(evt_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk("vec_ch", i, 32'(evt_ch), 32'(vecs[i].exp_ch));
                chk("vec_rising", i, 32'(evt_rising), 32'(vecs[i].exp_rising));
            end
            chk("vec_pend", i, 32'(pending), 32'(vecs[i].exp_pend));
            chk("vec_ovf", i, 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // stalled output: rise held, fall queued, second rise dropped
        evt_ready = 1'b0; din = 4'b1011;
        repeat (3) step();
        chk("t4_pend0", 0, 32'(pending), 32'b0010);
        chk("t4_valid0", 0, 32'(evt_valid), 32'd0);
        step();
        chk("t4_valid1", 1, 32'(evt_valid), 32'd1);
        chk("t4_ch1", 1, 32'(evt_ch), 32'd1);
        chk("t4_rise1", 1, 32'(evt_rising), 32'd1);
        chk("t4_pend1", 1, 32'(pending), 32'd0);
        din = 4'b1001;
        repeat (3) step();
        chk("t4_pend2", 2, 32'(pending), 32'b0010);
        chk("t4_valid2", 2, 32'(evt_valid), 32'd1);
        chk("t4_rise2", 2, 32'(evt_rising), 32'd1);
        chk("t4_ovf2", 2, 32'(overflow), 32'd0);
        step();
        din = 4'b1011;
        repeat (3) step();
        chk("t4_ovf3", 3, 32'(overflow), 32'b0010);
        chk("t4_pend3", 3, 32'(pending), 32'b0010);
        chk("t4_ch3", 3, 32'(evt_ch), 32'd1);
        chk("t4_rise3", 3, 32'(evt_rising), 32'd1);
        evt_ready = 1'b1;
        step();
        chk("t4_valid4", 4, 32'(evt_valid), 32'd1);
        chk("t4_ch4", 4, 32'(evt_ch), 32'd1);
        chk("t4_rise4", 4, 32'(evt_rising), 32'd0);
        chk("t4_pend4", 4, 32'(pending), 32'd0);
        step();
        chk("t4_valid5", 5, 32'(evt_valid), 32'd0);
        chk("t4_ovf5", 5, 32'(overflow), 32'b0010);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("t4_ovfclr", 6, 32'(overflow), 32'd0);

        // falling edges masked: in[0] 1->0->1->0->1 gives two rising events
        fall_en = 4'h0; ev_cnt = 0; ev_bad = 0;
        din = 4'b1010; run(4, 2'd0);
        din = 4'b1011; run(4, 2'd0);
        din = 4'b1010; run(4, 2'd0);
        din = 4'b1011; run(8, 2'd0);
        chk("t5_count", 0, 32'(ev_cnt), 32'd2);
        chk("t5_kind", 0, 32'(ev_bad), 32'd0);

        // reset mid-cycle drops a held event; input high at release reads as a rise
        fall_en = 4'hF; evt_ready = 1'b0; din = 4'b1111;
        repeat (4) step();
        chk("t6_held", 0, 32'(evt_valid), 32'd1);
        chk("t6_held_ch", 0, 32'(evt_ch), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_async", 1, 32'(evt_valid), 32'd0);
        chk("t6_pend", 1, 32'(pending), 32'd0);
        din = 4'b1000;
        step();
        rst = 1'b1; evt_ready = 1'b1; ev_cnt = 0; ev_bad = 0;
        run(10, 2'd3);
        chk("t6_count", 2, 32'(ev_cnt), 32'd1);
        chk("t6_kind", 2, 32'(ev_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
